// File: rtl/edge_log_pkg.sv
// edge_log_pkg: shared edge-event kind codes and default widths
package edge_log_pkg;
  localparam logic EV_RISE = 1'b1;
  localparam logic EV_FALL = 1'b0;
  localparam int TS_W_DEF = 16;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-bit wrap pointers
// ports: clk, rst (sync, active high), push/din write, pop reads head,
//        full/empty status, dout = head entry (undefined while empty)
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd = pop && !empty;
  // a full FIFO still takes a write when the head leaves in the same cycle
  assign wr = push && (!full || rd);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/edge_event_logger.sv
// edge_event_logger: detects edges on sig_in, counts them, queues timestamped events
// ports: clk, rst (sync, active high), sig_in level, en record enable,
//        ev_valid/ev_ready/ev_kind/ev_time head-of-queue handshake,
//        rise_cnt/fall_cnt saturating counters, overflow sticky drop flag,
//        level registered sig_in
module edge_event_logger
  import edge_log_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             en,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic             ev_kind,
  output logic [TS_W-1:0]  ev_time,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             overflow,
  output logic             level
);
  logic [TS_W-1:0] ts;
  logic sig_q, hit, pop, full, empty, kind;
  logic [TS_W:0] head;
  assign hit = en && (sig_in != sig_q);
  assign kind = sig_in ? EV_RISE : EV_FALL;
  assign pop = ev_valid && ev_ready;
  assign ev_valid = !empty;
  assign ev_kind = empty ? EV_FALL : head[TS_W];
  assign ev_time = empty ? '0 : head[TS_W-1:0];
  assign level = sig_q;
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(1 + TS_W)) fifo (
    .clk(clk), .rst(rst), .push(hit), .pop(pop), .din({kind, ts}),
    .full(full), .empty(empty), .dout(head)
  );
  // sig_q loads sig_in during reset so releasing reset never looks like an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      ts <= '0;
      sig_q <= sig_in;
      rise_cnt <= '0;
      fall_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      sig_q <= sig_in;
      if (hit && sig_in && !(&rise_cnt)) rise_cnt <= rise_cnt + 1'b1;
      if (hit && !sig_in && !(&fall_cnt)) fall_cnt <= fall_cnt + 1'b1;
      if (hit && full && !pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_edge_event_logger.sv
// tb_edge_event_logger: table, directed and random checks against a queue-based model
module tb_edge_event_logger;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst, sig_in, en, ev_ready;
  logic ev_valid, ev_kind, overflow, level;
  logic [15:0] ev_time;
  logic [7:0] rise_cnt, fall_cnt;
  logic t_valid, t_kind, t_ovf, t_level;
  logic [3:0] t_time;
  logic [1:0] t_rise, t_fall;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  edge_event_logger #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_kind(ev_kind), .ev_time(ev_time), .rise_cnt(rise_cnt),
    .fall_cnt(fall_cnt), .overflow(overflow), .level(level)
  );
  edge_event_logger #(.DEPTH(DEPTH), .TS_W(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en), .ev_valid(t_valid),
    .ev_ready(ev_ready), .ev_kind(t_kind), .ev_time(t_time), .rise_cnt(t_rise),
    .fall_cnt(t_fall), .overflow(t_ovf), .level(t_level)
  );
  typedef struct {bit kind; int tm;} ev_t;
  ev_t q[$];
  int ts = 0, nr = 0, nf = 0;
  bit mov = 0, lvl = 0;
  function automatic int sat(input int n, input int w);
    return n > (1 << w) - 1 ? (1 << w) - 1 : n;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model(input logic r, input logic s, input logic e, input logic y);
    bit pop, hit, ok;
    if (r) begin
      q.delete();
      ts = 0; nr = 0; nf = 0; mov = 0; lvl = s;
    end else begin
      pop = (q.size() > 0) && y;
      hit = e && (s != lvl);
      ok = (q.size() < DEPTH) || pop;
      if (hit) begin
        if (s) nr++; else nf++;
      end
      if (pop) void'(q.pop_front());
      if (hit) begin
        if (ok) q.push_back('{s, ts});
        else mov = 1;
      end
      ts = (ts + 1) % 65536;
      lvl = s;
    end
  endtask
  task automatic cmp();
    int k, t;
    k = q.size() > 0 ? int'(q[0].kind) : 0;
    t = q.size() > 0 ? q[0].tm : 0;
    chk("valid", 32'(ev_valid), 32'(q.size() > 0));
    chk("kind", 32'(ev_kind), 32'(k));
    chk("time", 32'(ev_time), 32'(t));
    chk("rise", 32'(rise_cnt), 32'(sat(nr, 8)));
    chk("fall", 32'(fall_cnt), 32'(sat(nf, 8)));
    chk("overflow", 32'(overflow), 32'(mov));
    chk("level", 32'(level), 32'(lvl));
    chk("small_rise", 32'(t_rise), 32'(sat(nr, 2)));
    chk("small_fall", 32'(t_fall), 32'(sat(nf, 2)));
    chk("small_time", 32'(t_time), 32'(t % 16));
  endtask
  task automatic step(input logic r, input logic s, input logic e, input logic y);
    rst = r; sig_in = s; en = e; ev_ready = y;
    model(r, s, e, y);
    @(posedge clk);
    #1;
    cmp();
  endtask
  typedef struct {
    logic [3:0] in;
    logic v, k;
    logic [15:0] t;
    logic [7:0] rc, fc;
    logic ov, lv;
  } vec_t;
  vec_t tbl[13];
  initial begin
    logic s;
    int n;
    tbl[0] = '{4'b1111, 1'b0, 1'b0, 16'd0, 8'd0, 8'd0, 1'b0, 1'b1};
    for (int i = 1; i <= 5; i++) tbl[i] = '{4'b0111, 1'b0, 1'b0, 16'd0, 8'd0, 8'd0, 1'b0, 1'b1};
    tbl[6] = '{4'b1011, 1'b0, 1'b0, 16'd0, 8'd0, 8'd0, 1'b0, 1'b0};
    for (int i = 7; i <= 9; i++) tbl[i] = '{4'b0011, 1'b0, 1'b0, 16'd0, 8'd0, 8'd0, 1'b0, 1'b0};
    tbl[10] = '{4'b0111, 1'b1, 1'b1, 16'd3, 8'd1, 8'd0, 1'b0, 1'b1};
    tbl[11] = '{4'b0111, 1'b0, 1'b0, 16'd0, 8'd1, 8'd0, 1'b0, 1'b1};
    tbl[12] = '{4'b0111, 1'b0, 1'b0, 16'd0, 8'd1, 8'd0, 1'b0, 1'b1};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      chk("tbl_valid", 32'(ev_valid), 32'(tbl[i].v));
      chk("tbl_kind", 32'(ev_kind), 32'(tbl[i].k));
      chk("tbl_time", 32'(ev_time), 32'(tbl[i].t));
      chk("tbl_rise", 32'(rise_cnt), 32'(tbl[i].rc));
      chk("tbl_fall", 32'(fall_cnt), 32'(tbl[i].fc));
      chk("tbl_ovf", 32'(overflow), 32'(tbl[i].ov));
      chk("tbl_level", 32'(level), 32'(tbl[i].lv));
    end
    // overflow: five edges into four slots with the sink stalled
    step(1, 0, 1, 0);
    s = 0;
    for (int i = 0; i < 5; i++) begin s = ~s; step(0, s, 1, 0); end
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_total", 32'(rise_cnt) + 32'(fall_cnt), 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk("drain_kind", 32'(ev_kind), 32'(i % 2 == 0));
      chk("drain_time", 32'(ev_time), 32'(i));
      step(0, s, 1, 1);
    end
    chk("drain_empty", 32'(ev_valid), 32'd0);
    // full FIFO with a pop in the same cycle as a new edge
    step(1, 0, 1, 0);
    s = 0;
    for (int i = 0; i < 4; i++) begin s = ~s; step(0, s, 1, 0); end
    s = ~s;
    step(0, s, 1, 1);
    chk("full_pop_ovf", 32'(overflow), 32'd0);
    chk("full_pop_head", 32'(ev_time), 32'd1);
    n = 0;
    for (int i = 0; i < 10 && ev_valid; i++) begin
      if (n == 3) chk("full_pop_last", 32'(ev_time), 32'd4);
      n++;
      step(0, s, 1, 1);
    end
    chk("full_pop_count", 32'(n), 32'd4);
    // disabled recording, then enabled with a steady level
    step(1, 0, 1, 1);
    s = 0;
    for (int i = 0; i < 6; i++) begin s = ~s; step(0, s, 0, 1); end
    chk("en0_rise", 32'(rise_cnt), 32'd0);
    chk("en0_valid", 32'(ev_valid), 32'd0);
    for (int i = 0; i < 3; i++) step(0, s, 1, 1);
    chk("en1_steady", 32'(ev_valid), 32'd0);
    // reset while events are queued
    s = 0;
    for (int i = 0; i < 3; i++) begin s = ~s; step(0, s, 1, 0); end
    chk("pre_rst_valid", 32'(ev_valid), 32'd1);
    step(1, s, 1, 0);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_rise", 32'(rise_cnt), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    s = ~s;
    step(0, s, 1, 0);
    chk("rst_ts0", 32'(ev_time), 32'd0);
    // saturation on the narrow-counter instance
    step(1, 0, 1, 1);
    s = 0;
    for (int i = 0; i < 10; i++) begin s = ~s; step(0, s, 1, 1); end
    chk("sat_small", 32'(t_rise), 32'd3);
    chk("sat_wide", 32'(rise_cnt), 32'd5);
    // random traffic
    step(1, 0, 1, 0);
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) == 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
